// File: rtl/mips_word_mem_if.sv
// mips_word_mem_if
//
// Bundles the signals between the multi-cycle MIPS core's memory port and the
// word memory, together with the bench preload port and the sticky error
// flags, so that the memory and its driver see one connection.
//
// Signals:
//   mem_addr        byte address from the core MAR
//   mem_write_data  store data from the core B register
//   mem_read        read strobe (level)
//   mem_write       write strobe (level)
//   mem_read_data   registered read data
//   rd_valid        high while mem_read_data holds data for the current read
//   ld_we           preload write enable
//   ld_addr         preload word index
//   ld_data         preload data
//   err_misalign    sticky: access with mem_addr[1:0] != 0
//   err_oor         sticky: access or preload beyond the array
//   err_conflict    sticky: read and write strobes sampled together
//
// Modports:
//   master  the core / bench side that drives strobes and preloads
//   slave   the memory side that returns data and flags

interface mips_word_mem_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic        rd_valid;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        err_misalign;
    logic        err_oor;
    logic        err_conflict;

    // The requester drives addresses, strobes and preloads and observes
    // everything the memory reports back.
    modport master (
        output mem_addr,
        output mem_write_data,
        output mem_read,
        output mem_write,
        output ld_we,
        output ld_addr,
        output ld_data,
        input  mem_read_data,
        input  rd_valid,
        input  err_misalign,
        input  err_oor,
        input  err_conflict
    );

    // The memory sees the requester's signals as inputs and owns the read
    // data, the valid flag and the error flags.
    modport slave (
        input  mem_addr,
        input  mem_write_data,
        input  mem_read,
        input  mem_write,
        input  ld_we,
        input  ld_addr,
        input  ld_data,
        output mem_read_data,
        output rd_valid,
        output err_misalign,
        output err_oor,
        output err_conflict
    );

endinterface

// File: rtl/mips_word_mem.sv
// mips_word_mem
//
// Word-organised, fixed-latency memory placed directly behind the multi-cycle
// MIPS core's memory port. The core raises a level strobe and holds the
// address (and store data) stable; a read is answered after the strobe has
// been seen on READ_LAT consecutive rising edges at the same address. Writes
// commit on every edge their strobe is high. A preload port lets a bench fill
// the array, and sticky flags record misaligned, out-of-range and conflicting
// accesses until the next reset.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (word index = mem_addr[31:2])
//   READ_LAT     sampled edges of a stable read before data is returned (1..7)
//   OOR_DATA     value returned for reads beyond the array
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high; clears read state and flags but leaves
//          the array contents untouched
//   bus    mips_word_mem_if.slave carrying the core port, preload port and
//          error flags

module mips_word_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 2,
    parameter logic [31:0] OOR_DATA    = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    mips_word_mem_if.slave  bus
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    localparam logic [2:0]  LAT_U   = 3'(READ_LAT);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DONE
    } state_t;

    logic [31:0] memArray_q [DEPTH_WORDS];

    state_t      state_q,        state_d;
    logic [31:0] rdAddr_q,       rdAddr_d;
    logic [2:0]  rdCnt_q,        rdCnt_d;
    logic [31:0] rdData_q,       rdData_d;
    logic        rdValid_q,      rdValid_d;
    logic        errMisalign_q,  errMisalign_d;
    logic        errOor_q,       errOor_d;
    logic        errConflict_q,  errConflict_d;

    logic [29:0]   coreIdx;
    logic          coreInRange;
    logic          ldInRange;
    logic [AW-1:0] ldIdx;
    logic [31:0]   coreWord;
    logic          coreAccess;
    logic          conflict;
    logic          startRead;
    logic          finishRead;
    logic [2:0]    cntInc;

    // Address decode shared by reads, writes and error detection. The low two
    // address bits never take part in indexing, so a misaligned access still
    // lands on the enclosing word. Out-of-range reads return OOR_DATA instead
    // of touching the array.
    always_comb begin
        coreIdx     = bus.mem_addr[31:2];
        coreInRange = ({2'b00, coreIdx} < DEPTH_U);
        ldInRange   = (bus.ld_addr < DEPTH_U);
        ldIdx       = bus.ld_addr[AW-1:0];
        coreWord    = coreInRange ? memArray_q[coreIdx[AW-1:0]] : OOR_DATA;
        coreAccess  = bus.mem_read | bus.mem_write;
        conflict    = bus.mem_read & bus.mem_write;
    end

    // Array write ports. The array has no reset so a preloaded program
    // survives a core reset. The core write is placed after the preload so
    // that, when both target the same word on one edge, the core's data is
    // what ends up stored. Out-of-range writes of either kind are dropped.
    always_ff @(posedge clk) begin
        if (bus.ld_we && ldInRange) begin
            memArray_q[ldIdx] <= bus.ld_data;
        end
        if (bus.mem_write && coreInRange) begin
            memArray_q[coreIdx[AW-1:0]] <= bus.mem_write_data;
        end
    end

    // Read sequencer next-state logic. A read is counted from the first edge
    // its strobe is seen; any address change while the strobe stays high
    // restarts the count, so data always belongs to an address that was held
    // for the full latency. Dropping the strobe abandons the read but keeps
    // the last returned word on the output. Seeing both strobes together
    // performs only the write and abandons any read in progress. With a
    // one-cycle latency the starting edge is also the completing edge, which
    // is why start and finish are resolved after the state decode.
    always_comb begin
        state_d    = state_q;
        rdAddr_d   = rdAddr_q;
        rdCnt_d    = rdCnt_q;
        rdData_d   = rdData_q;
        rdValid_d  = rdValid_q;
        startRead  = 1'b0;
        finishRead = 1'b0;
        cntInc     = rdCnt_q + 3'd1;

        if (conflict) begin
            state_d   = IDLE;
            rdValid_d = 1'b0;
            rdCnt_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_read) begin
                        startRead = 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (!bus.mem_read) begin
                        state_d = IDLE;
                        rdCnt_d = 3'd0;
                    end else if (bus.mem_addr != rdAddr_q) begin
                        startRead = 1'b1;
                    end else begin
                        rdCnt_d = cntInc;
                        if (cntInc == LAT_U) begin
                            finishRead = 1'b1;
                        end
                    end
                end
                RD_DONE: begin
                    if (!bus.mem_read) begin
                        state_d   = IDLE;
                        rdValid_d = 1'b0;
                        rdCnt_d   = 3'd0;
                    end else if (bus.mem_addr != rdAddr_q) begin
                        startRead = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rdValid_d = 1'b0;
                    rdCnt_d   = 3'd0;
                end
            endcase
        end

        if (startRead) begin
            rdAddr_d  = bus.mem_addr;
            rdCnt_d   = 3'd1;
            rdValid_d = 1'b0;
            if (LAT_U == 3'd1) begin
                finishRead = 1'b1;
            end else begin
                state_d = RD_WAIT;
            end
        end

        if (finishRead) begin
            rdData_d  = coreWord;
            rdValid_d = 1'b1;
            state_d   = RD_DONE;
        end
    end

    // Sticky error flags. Each flag is set by the condition seen on any
    // sampled edge and is only ever cleared by reset, so a bench can inspect
    // them after a whole program has run.
    always_comb begin
        errMisalign_d = errMisalign_q | (coreAccess & (bus.mem_addr[1:0] != 2'b00));
        errOor_d      = errOor_q | (coreAccess & ~coreInRange) | (bus.ld_we & ~ldInRange);
        errConflict_d = errConflict_q | conflict;
    end

    // State and output registers. Reset abandons any read in flight and
    // clears the output word, the valid flag and the error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rdAddr_q      <= 32'd0;
            rdCnt_q       <= 3'd0;
            rdData_q      <= 32'd0;
            rdValid_q     <= 1'b0;
            errMisalign_q <= 1'b0;
            errOor_q      <= 1'b0;
            errConflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdAddr_q      <= rdAddr_d;
            rdCnt_q       <= rdCnt_d;
            rdData_q      <= rdData_d;
            rdValid_q     <= rdValid_d;
            errMisalign_q <= errMisalign_d;
            errOor_q      <= errOor_d;
            errConflict_q <= errConflict_d;
        end
    end

    // Everything the core sees comes straight from registers, so nothing on
    // the output side depends combinationally on the strobes.
    assign bus.mem_read_data = rdData_q;
    assign bus.rd_valid      = rdValid_q;
    assign bus.err_misalign  = errMisalign_q;
    assign bus.err_oor       = errOor_q;
    assign bus.err_conflict  = errConflict_q;

endmodule

// File: doc/mips_word_mem.md
Name: mips_word_mem

Overview:
- Word-organised, fixed-latency memory that sits directly downstream of the multi-cycle MIPS core's memory port (mem_addr / mem_read / mem_write / mem_write_data / mem_read_data).
- Honours the core's level-based strobe protocol: the core raises a strobe and holds address/data stable, then samples read data a fixed number of cycles later.
- Also provides a testbench preload port and sticky error flags for illegal accesses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; word index = mem_addr[31:2].
- READ_LAT, 2: number of consecutive rising edges at which mem_read must be sampled high (same address) before mem_read_data is updated; legal range 1..7.
- OOR_DATA, 32'h0000_0000: value driven on reads whose word index is >= DEPTH_WORDS.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_addr  in  32  byte address from core MAR
- mem_write_data  in  32  store data from core B register
- mem_read  in  1  read strobe (level)
- mem_write  in  1  write strobe (level)
- mem_read_data  out  32  registered read data
- rd_valid  out  1  high while mem_read_data holds data for the current read
- ld_we  in  1  preload write enable (bench use)
- ld_addr  in  32  preload word index
- ld_data  in  32  preload data
- err_misalign  out  1  sticky: access with mem_addr[1:0] != 0
- err_oor  out  1  sticky: access or preload with index >= DEPTH_WORDS
- err_conflict  out  1  sticky: mem_read and mem_write sampled high together

Behaviour:
- Reset: when reset is sampled high, mem_read_data=0, rd_valid=0, all err_* = 0, state=IDLE, rd_cnt=0. The memory array is NOT cleared; contents survive reset.
- State machine (states IDLE, RD_WAIT, RD_DONE):
  - IDLE: mem_read=1 and mem_write=0 -> latch word index into rd_idx, rd_cnt=1. If READ_LAT==1, update data and go to RD_DONE on this same edge; otherwise go to RD_WAIT.
  - RD_WAIT: mem_read=1 with the same mem_addr -> rd_cnt++. When rd_cnt reaches READ_LAT on an edge, mem_read_data <= mem[rd_idx] (or OOR_DATA) and state -> RD_DONE with rd_valid=1.
  - RD_WAIT, mem_addr changes while mem_read=1: restart (rd_idx reloaded, rd_cnt=1, stay in RD_WAIT).
  - RD_WAIT, mem_read=0: abort -> IDLE; mem_read_data unchanged.
  - RD_DONE: hold mem_read_data while mem_read=1 with the same address. mem_read=0 -> IDLE, rd_valid=0, mem_read_data held. Address change with mem_read=1 -> RD_WAIT restart, rd_valid=0.
- Default timing (READ_LAT=2): core sets MRE/MAR at edge E0; memory samples at E1 and E2; data is registered at E2 and is stable before E3, where the core's IR/MDR captures it.
- Writes:
  - Every edge with mem_write=1 commits mem[mem_addr[31:2]] <= mem_write_data; the write is idempotent if the strobe is held.
  - A write never changes mem_read_data.
- Read-after-write: a read started on the edge after a write returns the new data.
- Conflict: if mem_read=1 and mem_write=1 are sampled together, the write is performed, err_conflict is set, the read state machine goes to IDLE and rd_valid=0.
- Misaligned access: mem_addr[1:0] is ignored for indexing (access still performed); err_misalign is set on the first sampled edge of the access.
- Out of range:
  - Write: index >= DEPTH_WORDS -> write dropped, err_oor set.
  - Read: returns OOR_DATA at normal latency, err_oor set.
- Preload:
  - ld_we=1 -> mem[ld_addr] <= ld_data on that edge; an out-of-range ld_addr sets err_oor.
  - Simultaneous preload and core write to the same index: the core write wins.
- Reset mid-read: the state machine and outputs return to reset values; the read is not completed.
- Error flags clear only on reset.

Test Plan:
- Preload mem[0]=32'h2008_0005. Core-style fetch: mem_addr=0 and mem_read=1 at E0, held 3 cycles -> mem_read_data=32'h2008_0005 and rd_valid=1 after E2; value held after mem_read drops.
- Write mem_addr=32'h40, data=32'hCAFE_F00D, mem_write high 1 cycle; then read 32'h40 -> 32'hCAFE_F00D after 2 sampled edges; no err_* set.
- Read 32'h40, then change mem_addr to 32'h44 after 1 sampled edge -> restart; data from 32'h44 appears only after 2 further sampled edges; rd_valid stays 0 in between.
- Access mem_addr=32'h42 -> err_misalign=1, word 0x10 accessed. Access mem_addr=32'h1000 (index 1024) -> read returns 0, write dropped, err_oor=1.
- mem_read=mem_write=1 on the same edge at 32'h8 with data 32'h1234 -> mem[2]=32'h1234, err_conflict=1, rd_valid=0.
- Assert reset during RD_WAIT -> mem_read_data=0, rd_valid=0, flags cleared; memory contents still readable and unchanged after reset.
